// File: rtl/dense_param_streamer.sv
// dense_param_streamer: streams int8 ROM bias/weights as float32, neuron-major, over valid/ready.
// Define WEIGHT_SCALE_EN to emit every non-zero element pre-scaled by 1/256.
module dense_param_streamer #(
   parameter int NB_INPUT   = 42,
   parameter int NB_NEURONS = 24,
   parameter int ADDR_W     = 12,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [31:0]       w_data,
   output logic              w_is_bias,
   output logic              w_last_n,
   output logic              w_last
);
   localparam int JW = NB_NEURONS > 1 ? $clog2(NB_NEURONS + 1) : 1;
   localparam int KW = $clog2(NB_INPUT + 1);
`ifdef WEIGHT_SCALE_EN
   localparam int EXP_BIAS = 119;
`else
   localparam int EXP_BIAS = 127;
`endif
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CVT  = 3'd2;
   localparam logic [2:0] S_OUT  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;
   logic [2:0]    state;
   logic [JW-1:0] j, nj;
   logic [KW-1:0] k, nk;
   logic          last_k, last_j;
   // bias[j] sits at k=0 and W[k-1][j] at NB_NEURONS*k, so one formula covers both
   function automatic logic [ADDR_W-1:0] addr_of(input logic [JW-1:0] jj, input logic [KW-1:0] kk);
      return ADDR_W'(BASE_ADDR) + ADDR_W'(kk) * ADDR_W'(NB_NEURONS) + ADDR_W'(jj);
   endfunction
   function automatic logic [31:0] to_f32(input logic [7:0] x);
      logic [7:0]  mag;
      logic [2:0]  p;
      logic [30:0] sh;
      mag = x[7] ? 8'(-x) : x;
      p = 3'd0;
      for (int i = 0; i < 8; i++) if (mag[i]) p = 3'(i);
      sh = 31'(mag) << (5'd23 - 5'(p));
      return (mag == 8'd0) ? 32'h0 : {x[7], 8'(EXP_BIAS) + 8'(p), sh[22:0]};
   endfunction
   always_comb begin
      last_k = k == KW'(NB_INPUT);
      last_j = j == JW'(NB_NEURONS - 1);
      nk     = last_k ? '0 : k + 1'b1;
      nj     = last_k ? j + 1'b1 : j;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         j         <= '0;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         w_valid   <= 1'b0;
         w_data    <= 32'h0;
         w_is_bias <= 1'b0;
         w_last_n  <= 1'b0;
         w_last    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state    <= S_RD;
               busy     <= 1'b1;
               mem_rd   <= 1'b1;
               mem_addr <= addr_of('0, '0);
               j        <= '0;
               k        <= '0;
            end
            S_RD: begin
               state  <= S_CVT;
               mem_rd <= 1'b0;
            end
            S_CVT: begin
               state     <= S_OUT;
               w_valid   <= 1'b1;
               w_data    <= to_f32(mem_rdata);
               w_is_bias <= k == '0;
               w_last_n  <= last_k;
               w_last    <= last_k & last_j;
            end
            S_OUT: if (w_ready) begin
               w_valid <= 1'b0;
               j       <= nj;
               k       <= nk;
               if (last_k && last_j) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end else begin
                  state    <= S_RD;
                  mem_rd   <= 1'b1;
                  mem_addr <= addr_of(nj, nk);
               end
            end
            S_FIN: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dense_param_streamer.sv
// tb_dense_param_streamer: ROM model plus spec-order stream model, checked every cycle.
// Honours WEIGHT_SCALE_EN for the expected float encodings.
module tb_dense_param_streamer;
   localparam int NI = 42;
   localparam int NN = 24;
   localparam int NE = NN * (NI + 1);
   localparam int AW = 12;
   localparam int BASE = 0;
`ifdef WEIGHT_SCALE_EN
   localparam int EXPB = 119;
   localparam logic [31:0] F_127 = 32'h3EFE0000, F_M6 = 32'hBCC00000, F_1 = 32'h3B800000;
   localparam logic [31:0] F_M1 = 32'hBB800000, F_M128 = 32'hBF000000;
`else
   localparam int EXPB = 127;
   localparam logic [31:0] F_127 = 32'h42FE0000, F_M6 = 32'hC0C00000, F_1 = 32'h3F800000;
   localparam logic [31:0] F_M1 = 32'hBF800000, F_M128 = 32'hC3000000;
`endif
   typedef struct {logic [31:0] d; logic [2:0] f;} el_t;
   logic          clk = 0, rst_n = 0, start = 0, w_ready = 0;
   logic          busy, done, mem_rd, w_valid, w_is_bias, w_last_n, w_last;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata = 8'h0;
   logic [31:0]   w_data;
   logic [7:0]    rom [0:(1<<AW)-1];
   el_t           exp_q[$];
   logic [AW-1:0] addr_q[$];
   logic [31:0]   hs_data [0:NE-1];
   int            n_vec = 0, n_fail = 0, duty = 100;
   int            hs_cnt, rd_cnt, done_cnt, ln_cnt, l_cnt;
   logic [AW-1:0] first_addr;
   logic          pv = 0, pr = 0;
   logic [31:0]   pd = 0;
   logic [2:0]    pf = 0;
   dense_param_streamer #(.NB_INPUT(NI), .NB_NEURONS(NN), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .w_valid(w_valid), .w_ready(w_ready),
      .w_data(w_data), .w_is_bias(w_is_bias), .w_last_n(w_last_n), .w_last(w_last));
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];
   initial forever begin
      @(posedge clk);
      #1 w_ready = $urandom_range(0, 99) < duty;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
      end
   endtask
   // float value = sign * 2^e * (1 + frac), found by repeated halving
   function automatic logic [31:0] f32(input logic signed [7:0] x);
      int v, m, e, t;
      v = x;
      m = v < 0 ? -v : v;
      if (m == 0) return 32'h0;
      e = 0;
      t = m;
      while (t > 1) begin t = t / 2; e++; end
      return {v < 0, 8'(EXPB + e), 23'((m - (1 << e)) << (23 - e))};
   endfunction
   always @(negedge clk) begin
      if (!rst_n) pv = 0;
      else begin
         if (pv && !pr) begin
            chk("hold_valid", 32'(w_valid), 32'd1);
            chk("hold_data", w_data, pd);
            chk("hold_flags", 32'({w_is_bias, w_last_n, w_last}), 32'(pf));
         end
         if (mem_rd) begin
            chk("rd_while_valid", 32'(w_valid), 32'd0);
            if (rd_cnt == 0) first_addr = mem_addr;
            if (addr_q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            rd_cnt++;
         end
         if (w_valid && w_ready) begin
            if (hs_cnt < NE) hs_data[hs_cnt] = w_data;
            if (exp_q.size() > 0) begin
               el_t e;
               e = exp_q.pop_front();
               chk("w_data", w_data, e.d);
               chk("w_flags", 32'({w_is_bias, w_last_n, w_last}), 32'(e.f));
            end
            if (w_last_n) ln_cnt++;
            if (w_last) l_cnt++;
            hs_cnt++;
         end
         if (done) done_cnt++;
         pv = w_valid;
         pr = w_ready;
         pd = w_data;
         pf = {w_is_bias, w_last_n, w_last};
      end
   end
   task automatic run_layer(input int d, input int mid_at, input int rst_at);
      int c;
      exp_q.delete();
      addr_q.delete();
      for (int j = 0; j < NN; j++)
         for (int k = 0; k <= NI; k++) begin
            int a;
            a = BASE + k * NN + j;
            addr_q.push_back(AW'(a));
            exp_q.push_back('{f32(rom[a]), {k == 0, k == NI, k == NI && j == NN - 1}});
         end
      hs_cnt = 0; rd_cnt = 0; done_cnt = 0; ln_cnt = 0; l_cnt = 0;
      duty = d;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      chk("busy_after_start", 32'(busy), 32'd1);
      c = 0;
      while (!done && c < 20000) begin
         @(negedge clk);
         c++;
         if (c == mid_at) begin
            start = 1;
            @(negedge clk) start = 0;
         end
         if (rst_at > 0 && hs_cnt >= rst_at) begin
            #2 rst_n = 0;
            #1 chk("rst_outputs", 32'({busy, done, mem_rd, w_valid, w_is_bias, w_last_n, w_last}), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_data", w_data, 32'h0);
            @(negedge clk) rst_n = 1;
            return;
         end
      end
      chk("done_seen", 32'(done), 32'd1);
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      chk("handshakes", hs_cnt, NE);
      chk("mem_reads", rd_cnt, NE);
      chk("done_count", done_cnt, 1);
      chk("last_n_count", ln_cnt, NN);
      chk("last_count", l_cnt, 1);
      chk("first_addr", 32'(first_addr), BASE);
   endtask
   initial begin
      for (int a = 0; a < (1 << AW); a++) rom[a] = 8'($urandom_range(0, 255));
      rom[BASE] = 8'd127;
      rom[BASE + NN] = 8'hFA;
      rom[BASE + 1] = 8'd0;
      rom[BASE + 2] = 8'd1;
      rom[BASE + 3] = 8'hFF;
      rom[BASE + 4] = 8'h80;
      #13;
      chk("reset_flags", 32'({busy, done, mem_rd, w_valid, w_is_bias, w_last_n, w_last}), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_data", w_data, 32'h0);
      chk("model_0", f32(8'sd0), 32'h0);
      chk("model_1", f32(8'sd1), F_1);
      chk("model_m1", f32(-8'sd1), F_M1);
      chk("model_m128", f32(-8'sd128), F_M128);
      chk("model_127", f32(8'sd127), F_127);
      chk("model_m6", f32(-8'sd6), F_M6);
      @(negedge clk) rst_n = 1;
      run_layer(100, 0, 0);
      chk("first_elem", hs_data[0], F_127);
      chk("second_elem", hs_data[1], F_M6);
      chk("bias1_zero", hs_data[(NI + 1) * 1], 32'h0);
      chk("bias2_one", hs_data[(NI + 1) * 2], F_1);
      chk("bias3_m1", hs_data[(NI + 1) * 3], F_M1);
      chk("bias4_m128", hs_data[(NI + 1) * 4], F_M128);
      run_layer(30, 300, 0);
      run_layer(100, 0, 500);
      run_layer(100, 0, 0);
      chk("restart_first", hs_data[0], F_127);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
